// File: rtl/noc_pkg.sv
// Shared types for the linear NoC source-side injector.
// Node id width, flit field positions, send FSM states.
package noc_pkg;

  localparam int ID_W     = 2;
  localparam int FLIT_W   = 16;
  localparam int DEST_MSB = FLIT_W - 1;
  localparam int DEST_LSB = FLIT_W - 2;

  typedef enum logic [1:0] {
    RUN,
    LAST,
    WAIT
  } send_st_t;

endpackage

// File: rtl/noc_injector_if.sv
// PE request channel and router local write port bundle.
// master: PE + router side; slave: the injector.
interface noc_injector_if
  import noc_pkg::*;
#(
  parameter int WIDTH = FLIT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [ID_W-1:0]  in_dest;
  logic [WIDTH-3:0] in_payload;
  logic             noc_write;
  logic [WIDTH-1:0] noc_data;
  logic             noc_full;
  logic             noc_almost_full;

  modport master (
    output in_valid,
    output in_dest,
    output in_payload,
    output noc_full,
    output noc_almost_full,
    input  in_ready,
    input  noc_write,
    input  noc_data
  );

  modport slave (
    input  in_valid,
    input  in_dest,
    input  in_payload,
    input  noc_full,
    input  noc_almost_full,
    output in_ready,
    output noc_write,
    output noc_data
  );

endinterface

// File: rtl/noc_injq.sv
// Circular request FIFO: push, pop, head, full, empty, count.
// Push while full is allowed when a pop frees the slot on the same edge.
module noc_injq
  import noc_pkg::*;
#(
  parameter int WIDTH  = FLIT_W,
  parameter int QDEPTH = 4,
  parameter int QADDR  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [QADDR:0]   count
);

  localparam logic [QADDR:0] DEPTH = QDEPTH[QADDR:0];

  logic [WIDTH-1:0] mem [QDEPTH];
  logic [QADDR-1:0] wptr;
  logic [QADDR-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case (1'b1)
        do_push && !do_pop: count <= count + 1'b1;
        do_pop && !do_push: count <= count - 1'b1;
        default:            count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_injector.sv
// Source-side NoC network interface: queues PE requests, formats flits,
// throttles router writes on full/almost_full, counts sends and self-drops.
module noc_injector
  import noc_pkg::*;
#(
  parameter int              WIDTH   = FLIT_W,
  parameter int              QDEPTH  = 4,
  parameter int              QADDR   = 2,
  parameter logic [ID_W-1:0] NODE_ID = 2'b00
) (
  input  logic           clk,
  input  logic           reset,
  noc_injector_if.slave  bus,
  output logic [15:0]    sent_count,
  output logic [7:0]     drop_count
);

  send_st_t         st;
  logic             can_send;
  logic             send;
  logic             accept;
  logic             self_req;
  logic             q_full;
  logic             q_empty;
  logic [WIDTH-1:0] q_head;
  logic [QADDR:0]   q_count;
  logic             unused_ok;

  assign unused_ok = ^q_count;

  always_comb begin
    can_send = 1'b0;
    unique case (st)
      RUN:     can_send = !bus.noc_full && !bus.noc_almost_full;
      LAST:    can_send = !bus.noc_full;
      default: can_send = 1'b0;
    endcase
  end

  // reset gating keeps the reset cycle silent on both sides
  assign send          = !q_empty && can_send && !reset;
  assign bus.noc_write = send;
  assign bus.noc_data  = q_empty ? '0 : q_head;
  assign bus.in_ready  = !q_full && !reset;

  assign accept   = bus.in_valid && bus.in_ready;
  assign self_req = (bus.in_dest == NODE_ID);

  noc_injq #(
    .WIDTH  (WIDTH),
    .QDEPTH (QDEPTH),
    .QADDR  (QADDR)
  ) u_q (
    .clk   (clk),
    .reset (reset),
    .push  (accept && !self_req),
    .pop   (send),
    .din   ({bus.in_dest, bus.in_payload}),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= RUN;
      sent_count <= '0;
      drop_count <= '0;
    end else begin
      unique case (st)
        RUN: begin
          if (bus.noc_full)             st <= WAIT;
          else if (bus.noc_almost_full) st <= LAST;
        end
        LAST: begin
          if (bus.noc_full || send)      st <= WAIT;
          else if (!bus.noc_almost_full) st <= RUN;
        end
        WAIT: begin
          if (!bus.noc_full && !bus.noc_almost_full) st <= RUN;
        end
        default: st <= RUN;
      endcase
      if (send) sent_count <= sent_count + 16'd1;
      if (accept && self_req && drop_count != 8'hff)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule
